imm_narrow_pipe: RTL

//   Streaming 32-bit -> 17-bit signed narrowing unit; inverse of the immediate sign-extension path.

---
 rtl/imm_narrow_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/imm_narrow_pipe.sv
// rtl/imm_narrow_pipe.sv - 32-to-17-bit signed narrowing pipeline with overflow flag and saturating counter (optional macro: SATURATE_EN)
module imm_narrow_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 17,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    input  logic                 clr_count,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Stage 1: low field, sign bit and range verdict of the accepted word
    logic                 s1_valid_q;
    logic [OUT_WIDTH-1:0] s1_low_q;
    logic                 s1_sign_q;
    logic                 s1_inrange_q;

    // Stage 2: the output register
    logic                 s2_valid_q;
    logic [OUT_WIDTH-1:0] s2_data_q;
    logic [OUT_WIDTH-1:0] s2_data_d;
    logic                 s2_ovf_q;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic                         adv1;
    logic                         adv2;
    logic                         accept;
    logic                         in_range;
    logic [IN_WIDTH-OUT_WIDTH:0]  upper_bits;

    assign upper_bits = in_data[IN_WIDTH-1:OUT_WIDTH-1];
    assign in_range   = (&upper_bits) | ~(|upper_bits);

    assign adv2     = ~s2_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1 & ~reset;
    assign accept   = in_valid & in_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;
    assign ovf_count = cnt_q;

    // Valid bits of both stages; reset flushes anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (adv1) s1_valid_q <= in_valid;
            if (adv2) s2_valid_q <= s1_valid_q;
        end
    end

    // Stage 1 payload; only loaded on a real transfer so idle inputs are ignored
    always_ff @(posedge clock) begin
        if (accept) begin
            s1_low_q     <= in_data[OUT_WIDTH-1:0];
            s1_sign_q    <= in_data[IN_WIDTH-1];
            s1_inrange_q <= in_range;
        end
    end

    // Narrowed value: wrap by default, clamp to the signed limits when saturating
    always_comb begin
        s2_data_d = s1_low_q;
`ifdef SATURATE_EN
        if (!s1_inrange_q) s2_data_d = s1_sign_q ? MIN_NEG : MAX_POS;
`endif
    end

    // Output register holds steady while the consumer stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_data_q <= '0;
            s2_ovf_q  <= 1'b0;
        end else if (adv2 && s1_valid_q) begin
            s2_data_q <= s2_data_d;
            s2_ovf_q  <= ~s1_inrange_q;
        end
    end

    // Overflow count: clear wins over increment, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (accept && !in_range && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule
